// File: rtl/descriptor_engine.sv
// descriptor_engine: walks a descriptor list held in the MPRF and emits
// addressed data words to the outbound buffer under a valid/ready handshake.
// The header word sets the base output address. Descriptors can emit a
// literal word, emit one indirect word, emit a burst of words, or move the
// output address. An all-zero terminator emits one completion word.
module descriptor_engine #(
    parameter int DATA_W    = 32,
    parameter int MPRF_AW   = 5,
    parameter int OUT_AW    = 10,
    parameter int FLAG_BITS = 5,
    parameter logic [DATA_W-1:0] DONE_WORD = {{(DATA_W-1){1'b0}}, 1'b1}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MPRF_AW-1:0] start_addr,
    output logic [MPRF_AW-1:0] mprf_addr,
    output logic               mprf_rd_en,
    input  logic [DATA_W-1:0]  mprf_rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_AW-1:0]  out_addr,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        DRD    = 3'd3,
        DWAIT  = 3'd4,
        EMIT   = 3'd5,
        FIN    = 3'd6
    } state_t;

    localparam logic [2:0]         OP_LIT   = 3'b000;
    localparam logic [2:0]         OP_IND   = 3'b001;
    localparam logic [2:0]         OP_BURST = 3'b010;
    localparam logic [2:0]         OP_SETA  = 3'b011;
    localparam logic [MPRF_AW-1:0] PC_ONE   = MPRF_AW'(1'b1);
    localparam logic [OUT_AW-1:0]  ADDR_ONE = OUT_AW'(1'b1);
    localparam logic [7:0]         CNT_ONE  = 8'd1;

    state_t              state_r, state_nxt_s;
    logic [MPRF_AW-1:0]  pc_r, pc_nxt_s;
    logic [MPRF_AW-1:0]  src_r, src_nxt_s;
    logic [OUT_AW-1:0]   base_r, base_nxt_s;
    logic [OUT_AW-1:0]   cur_addr_r, cur_addr_nxt_s;
    logic [7:0]          cnt_r, cnt_nxt_s;
    logic                hdr_r, hdr_nxt_s;
    logic                multi_r, multi_nxt_s;
    logic                err_r, err_nxt_s;
    logic                out_valid_r, out_valid_nxt_s;
    logic [OUT_AW-1:0]   out_addr_r, out_addr_nxt_s;
    logic [DATA_W-1:0]   out_data_r, out_data_nxt_s;
    logic [MPRF_AW-1:0]  mprf_addr_r, mprf_addr_nxt_s;
    logic                mprf_rd_en_r, mprf_rd_en_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_s;
    logic [2:0]          op_s;
    logic [OUT_AW-1:0]   flag_addr_s;

    assign op_s        = mprf_rd_data[DATA_W-1:DATA_W-3];
    // Completion address: base with its low FLAG_BITS bits forced to ones.
    assign flag_addr_s = {base_r[OUT_AW-1:FLAG_BITS], {FLAG_BITS{1'b1}}};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r         <= '0;
            src_r        <= '0;
            base_r       <= '0;
            cur_addr_r   <= '0;
            cnt_r        <= 8'd0;
            hdr_r        <= 1'b0;
            multi_r      <= 1'b0;
            err_r        <= 1'b0;
            out_valid_r  <= 1'b0;
            out_addr_r   <= '0;
            out_data_r   <= '0;
            mprf_addr_r  <= '0;
            mprf_rd_en_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            pc_r         <= pc_nxt_s;
            src_r        <= src_nxt_s;
            base_r       <= base_nxt_s;
            cur_addr_r   <= cur_addr_nxt_s;
            cnt_r        <= cnt_nxt_s;
            hdr_r        <= hdr_nxt_s;
            multi_r      <= multi_nxt_s;
            err_r        <= err_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_addr_r   <= out_addr_nxt_s;
            out_data_r   <= out_data_nxt_s;
            mprf_addr_r  <= mprf_addr_nxt_s;
            mprf_rd_en_r <= mprf_rd_en_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        src_nxt_s      = src_r;
        base_nxt_s     = base_r;
        cur_addr_nxt_s = cur_addr_r;
        cnt_nxt_s      = cnt_r;
        hdr_nxt_s      = hdr_r;
        multi_nxt_s    = multi_r;
        err_nxt_s      = err_r;
        out_data_nxt_s = out_data_r;
        done_s         = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    pc_nxt_s    = start_addr;
                    hdr_nxt_s   = 1'b1;
                    err_nxt_s   = 1'b0;
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                state_nxt_s = DECODE;
            end
            DECODE: begin
                if (hdr_r) begin
                    base_nxt_s     = mprf_rd_data[OUT_AW-1:0];
                    cur_addr_nxt_s = mprf_rd_data[OUT_AW-1:0];
                    hdr_nxt_s      = 1'b0;
                    pc_nxt_s       = pc_r + PC_ONE;
                    state_nxt_s    = FETCH;
                end else begin
                    case (op_s)
                        OP_LIT: begin
                            if (mprf_rd_data == '0) begin
                                out_data_nxt_s = DONE_WORD;
                                state_nxt_s    = FIN;
                            end else begin
                                out_data_nxt_s = mprf_rd_data;
                                multi_nxt_s    = 1'b0;
                                state_nxt_s    = EMIT;
                            end
                        end
                        OP_IND: begin
                            src_nxt_s   = mprf_rd_data[MPRF_AW-1:0];
                            cnt_nxt_s   = CNT_ONE;
                            multi_nxt_s = 1'b1;
                            state_nxt_s = DRD;
                        end
                        OP_BURST: begin
                            src_nxt_s   = mprf_rd_data[MPRF_AW-1:0];
                            cnt_nxt_s   = mprf_rd_data[15:8];
                            multi_nxt_s = 1'b1;
                            // A zero-length burst is skipped like a no-op.
                            if (mprf_rd_data[15:8] == 8'd0) begin
                                pc_nxt_s    = pc_r + PC_ONE;
                                state_nxt_s = FETCH;
                            end else begin
                                state_nxt_s = DRD;
                            end
                        end
                        OP_SETA: begin
                            cur_addr_nxt_s = mprf_rd_data[OUT_AW-1:0];
                            pc_nxt_s       = pc_r + PC_ONE;
                            state_nxt_s    = FETCH;
                        end
                        default: begin
                            err_nxt_s   = 1'b1;
                            done_s      = 1'b1;
                            state_nxt_s = IDLE;
                        end
                    endcase
                end
            end
            DRD: begin
                state_nxt_s = DWAIT;
            end
            DWAIT: begin
                out_data_nxt_s = mprf_rd_data;
                state_nxt_s    = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    cur_addr_nxt_s = cur_addr_r + ADDR_ONE;
                    if (multi_r && (cnt_r > CNT_ONE)) begin
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                        src_nxt_s   = src_r + PC_ONE;
                        state_nxt_s = DRD;
                    end else begin
                        pc_nxt_s    = pc_r + PC_ONE;
                        state_nxt_s = FETCH;
                    end
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            FIN: begin
                if (out_ready) begin
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // Registered outputs follow the state being entered so they line up
        // with that state on the next cycle.
        out_valid_nxt_s  = (state_nxt_s == EMIT) || (state_nxt_s == FIN);
        mprf_rd_en_nxt_s = (state_nxt_s == FETCH) || (state_nxt_s == DRD);
        busy_nxt_s       = (state_nxt_s != IDLE);

        if (state_nxt_s == EMIT) begin
            out_addr_nxt_s = cur_addr_nxt_s;
        end else if (state_nxt_s == FIN) begin
            out_addr_nxt_s = flag_addr_s;
        end else begin
            out_addr_nxt_s = out_addr_r;
        end

        if (state_nxt_s == FETCH) begin
            mprf_addr_nxt_s = pc_nxt_s;
        end else if (state_nxt_s == DRD) begin
            mprf_addr_nxt_s = src_nxt_s;
        end else begin
            mprf_addr_nxt_s = mprf_addr_r;
        end
    end

    assign mprf_addr  = mprf_addr_r;
    assign mprf_rd_en = mprf_rd_en_r;
    assign out_valid  = out_valid_r;
    assign out_addr   = out_addr_r;
    assign out_data   = out_data_r;
    assign busy       = busy_r;
    assign done       = done_s;
    assign err        = err_r;

endmodule

// File: tb/tb_descriptor_engine.sv
// Testbench for descriptor_engine: an MPRF model with one-cycle read latency,
// a capture monitor for accepted output words, a table of expected words per
// walk, and hand-written sequences for backpressure, errors and reset.
module tb_descriptor_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  start_addr;
    logic [4:0]  mprf_addr;
    logic        mprf_rd_en;
    logic [31:0] mprf_rd_data = 32'd0;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] mem [32];
    logic [41:0] cap_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;

    typedef struct {
        int          walk;
        logic [9:0]  addr;
        logic [31:0] data;
    } vec_t;
    vec_t vecs [11];

    descriptor_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_addr   (start_addr),
        .mprf_addr    (mprf_addr),
        .mprf_rd_en   (mprf_rd_en),
        .mprf_rd_data (mprf_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // MPRF model: data returned one cycle after the read strobe.
    always @(posedge clk) begin
        if (mprf_rd_en) mprf_rd_data <= mem[mprf_addr];
    end

    // Record every accepted word and every done pulse.
    always @(posedge clk) begin
        if (out_valid && out_ready) cap_q.push_back({out_addr, out_data});
        if (done) done_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Compare the captured words with the table rows of walk w.
    task automatic check_walk(input int w, input string nm);
        int k;
        k = 0;
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].walk == w) begin
                if (k < cap_q.size())
                    chk({nm, "_word"}, {22'd0, cap_q[k]}, {22'd0, vecs[i].addr, vecs[i].data});
                k++;
            end
        end
        chk({nm, "_count"}, 64'(cap_q.size()), 64'(k));
    endtask

    // mode 0: out_ready held high; mode 1: hold out_ready low 5 cycles per word.
    // poke: pulse start mid-walk and again in the done cycle (both ignored).
    task automatic run_walk(input logic [4:0] sa, input int mode, input bit poke, output int first_v);
        int          hold;
        bit          seen;
        logic [9:0]  h_addr;
        logic [31:0] h_data;
        hold = 0; seen = 1'b0; first_v = -1; h_addr = 10'd0; h_data = 32'd0;
        cap_q.delete();
        @(negedge clk);
        start = 1'b1; start_addr = sa; out_ready = (mode == 0);
        @(negedge clk);
        start = 1'b0;
        chk("first_read_en", 64'(mprf_rd_en), 64'd1);
        chk("first_read_addr", 64'(mprf_addr), 64'(sa));
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (poke && cyc == 3) begin
                start = 1'b1; start_addr = 5'd11;
            end else begin
                start = 1'b0;
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (cyc == 2) chk("busy_mid", 64'(busy), 64'd1);
            if (mode == 1) begin
                if (out_valid) begin
                    if (hold == 0) begin
                        h_addr = out_addr; h_data = out_data;
                    end else begin
                        chk("bp_valid", 64'(out_valid), 64'd1);
                        chk("bp_addr", 64'(out_addr), 64'(h_addr));
                        chk("bp_data", 64'(out_data), 64'(h_data));
                    end
                    if (hold < 5) begin
                        out_ready = 1'b0; hold++;
                    end else begin
                        out_ready = 1'b1; hold = 0;
                    end
                end else begin
                    out_ready = 1'b0;
                end
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (done) begin
                seen = 1'b1;
                if (poke) begin
                    start = 1'b1; start_addr = 5'd11;
                end
            end
        end
        chk("walk_done", 64'(seen), 64'd1);
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        int  fv;
        int  d0;
        bit  found;

        vecs[0]  = '{0, 10'h040, 32'h0000_1234};
        vecs[1]  = '{0, 10'h041, 32'h0000_5678};
        vecs[2]  = '{0, 10'h05F, 32'h0000_0001};
        vecs[3]  = '{1, 10'h100, 32'h0000_00AA};
        vecs[4]  = '{1, 10'h101, 32'h0000_0001};
        vecs[5]  = '{1, 10'h102, 32'h0000_0002};
        vecs[6]  = '{1, 10'h103, 32'h0000_0003};
        vecs[7]  = '{1, 10'h11F, 32'h0000_0001};
        vecs[8]  = '{2, 10'h3FF, 32'h0000_0111};
        vecs[9]  = '{2, 10'h000, 32'h0000_0222};
        vecs[10] = '{2, 10'h3FF, 32'h0000_0001};

        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        // Literal walk at 2.
        mem[2]  = 32'h0000_0040; mem[3]  = 32'h0000_1234; mem[4]  = 32'h0000_5678; mem[5]  = 32'h0;
        // Indirect + burst + zero-length burst at 6.
        mem[6]  = 32'h0000_0100; mem[7]  = 32'h2000_0014; mem[8]  = 32'h4000_0310;
        mem[9]  = 32'h4000_0010; mem[10] = 32'h0;
        // Set address with output-address wrap at 11.
        mem[11] = 32'h0000_03FE; mem[12] = 32'h6000_03FF; mem[13] = 32'h0000_0111;
        mem[14] = 32'h0000_0222; mem[15] = 32'h0;
        mem[16] = 32'h1; mem[17] = 32'h2; mem[18] = 32'h3; mem[20] = 32'h0000_00AA;
        // Illegal opcode 101 at 22.
        mem[21] = 32'h0000_0300; mem[22] = 32'hA000_0000;

        rst = 1'b1; start = 1'b0; start_addr = 5'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({out_valid, out_addr, out_data, mprf_rd_en, mprf_addr, busy, done, err}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        d0 = done_cnt;
        run_walk(5'd2, 0, 1'b0, fv);
        repeat (3) @(negedge clk);
        check_walk(0, "lit");
        chk("lit_latency", 64'(fv), 64'd4);
        chk("lit_done_once", 64'(done_cnt - d0), 64'd1);
        chk("lit_err", 64'(err), 64'd0);
        chk("lit_busy_after", 64'(busy), 64'd0);

        d0 = done_cnt;
        run_walk(5'd6, 0, 1'b0, fv);
        repeat (3) @(negedge clk);
        check_walk(1, "ind_burst");
        chk("ind_latency", 64'(fv), 64'd6);
        chk("ind_done_once", 64'(done_cnt - d0), 64'd1);

        run_walk(5'd11, 0, 1'b0, fv);
        repeat (3) @(negedge clk);
        check_walk(2, "seta_wrap");

        d0 = done_cnt;
        run_walk(5'd6, 1, 1'b0, fv);
        repeat (3) @(negedge clk);
        check_walk(1, "backpressure");
        chk("bp_done_once", 64'(done_cnt - d0), 64'd1);

        d0 = done_cnt;
        run_walk(5'd21, 0, 1'b0, fv);
        repeat (3) @(negedge clk);
        chk("err_set", 64'(err), 64'd1);
        chk("err_no_emit", 64'(cap_q.size()), 64'd0);
        chk("err_done_once", 64'(done_cnt - d0), 64'd1);
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);

        run_walk(5'd2, 0, 1'b0, fv);
        repeat (3) @(negedge clk);
        check_walk(0, "lit_after_err");
        chk("err_cleared_by_start", 64'(err), 64'd0);

        run_walk(5'd21, 0, 1'b0, fv);
        chk("err_set_again", 64'(err), 64'd1);
        #2 rst = 1'b1;
        #1 chk("err_cleared_by_reset", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while the second burst word is stalled in EMIT.
        cap_q.delete();
        @(negedge clk);
        start = 1'b1; start_addr = 5'd6; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (out_valid && out_data == 32'h2) begin
                out_ready = 1'b0; found = 1'b1;
            end else begin
                out_ready = 1'b1;
                @(negedge clk);
            end
        end
        chk("burst_reached", 64'(found), 64'd1);
        repeat (2) @(negedge clk);
        chk("stall_held", 64'({out_valid, out_addr, out_data}), {21'd0, 1'b1, 10'h102, 32'h2});
        chk("pre_reset_words", 64'(cap_q.size()), 64'd2);
        #2 rst = 1'b1;
        #1 chk("reset_async_outputs", 64'({out_valid, out_addr, out_data, mprf_rd_en, mprf_addr, busy, done, err}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        d0 = done_cnt;
        run_walk(5'd2, 0, 1'b1, fv);
        repeat (5) @(negedge clk);
        check_walk(0, "after_reset");
        chk("after_reset_done_once", 64'(done_cnt - d0), 64'd1);
        chk("start_on_done_ignored", 64'(busy), 64'd0);
        chk("after_reset_err", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
